// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS main controller.
package mc_pkg;

  localparam int unsigned STATE_W   = 4;
  localparam int unsigned OP_W      = 6;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned ALUCTRL_W = 3;
  localparam int unsigned SEL_W     = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;

  typedef enum logic [SEL_W-1:0] {REGDST_RT, REGDST_RD, REGDST_RA} regdst_t;
  typedef enum logic [SEL_W-1:0] {M2R_ALUOUT, M2R_MDR, M2R_PC} memtoreg_t;
  typedef enum logic [SEL_W-1:0] {SRCB_B, SRCB_FOUR, SRCB_IMM, SRCB_IMMSH} srcb_t;
  typedef enum logic [SEL_W-1:0] {PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP} pcsrc_t;

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps ALU operation class and R-type funct to the ALU control code and funct validity.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [FUNCT_W-1:0]   funct,
  input  aluop_t               alu_op,
  output logic [ALUCTRL_W-1:0] alu_ctrl,
  output logic                 funct_valid
);

  always_comb begin
    alu_ctrl    = ALU_ADD;
    funct_valid = 1'b1;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: funct_valid = 1'b0;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_main_controller.sv
// Multicycle MIPS main control FSM driving all datapath enables and selects.
// Define MC_MAIN_CONTROLLER_JAL_EN to decode opcode 0x03 as jal.
module mc_main_controller
  import mc_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OP_W-1:0]      opcode,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 zero,
  output logic                 pcEn,
  output logic                 iorD,
  output logic                 memRead,
  output logic                 memWrite,
  output logic                 irWrite,
  output logic [SEL_W-1:0]     regDst,
  output logic [SEL_W-1:0]     memToReg,
  output logic                 regWrite,
  output logic                 aluSrcA,
  output logic [SEL_W-1:0]     aluSrcB,
  output logic [ALUCTRL_W-1:0] aluCtrl,
  output logic [SEL_W-1:0]     pcSrc,
  output logic                 illegalOp,
  output logic [STATE_W-1:0]   state
);

  localparam state_t ILLEGAL_NEXT = ILLEGAL_HALT ? S_HALT : S_FETCH;

  state_t                 state_q, state_d;
  logic                   pc_write, branch;
  logic                   ir_write_raw, mem_write_raw, reg_write_raw;
  logic                   alu_used;
  aluop_t                 alu_op;
  logic [ALUCTRL_W-1:0]   dec_ctrl;
  logic                   funct_ok;

  mc_alu_decoder u_alu_decoder (
    .funct       (funct),
    .alu_op      (alu_op),
    .alu_ctrl    (dec_ctrl),
    .funct_valid (funct_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    alu_used      = 1'b0;
    alu_op        = ALUOP_ADD;
    iorD          = 1'b0;
    memRead       = 1'b0;
    regDst        = REGDST_RT;
    memToReg      = M2R_ALUOUT;
    aluSrcA       = 1'b0;
    aluSrcB       = SRCB_B;
    pcSrc         = PCSRC_ALU;
    illegalOp     = 1'b0;
    case (state_q)
      S_FETCH: begin
        memRead      = 1'b1;
        ir_write_raw = 1'b1;
        aluSrcB      = SRCB_FOUR;
        alu_used     = 1'b1;
        pc_write     = 1'b1;
        state_d      = S_DECODE;
      end
      // Branch target is precomputed here while the opcode is decoded.
      S_DECODE: begin
        aluSrcB  = SRCB_IMMSH;
        alu_used = 1'b1;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_JAL: begin
`ifdef MC_MAIN_CONTROLLER_JAL_EN
            state_d = S_JAL;
`else
            illegalOp = 1'b1;
            state_d   = ILLEGAL_NEXT;
`endif
          end
          default: begin
            illegalOp = 1'b1;
            state_d   = ILLEGAL_NEXT;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcA  = 1'b1;
        aluSrcB  = SRCB_IMM;
        alu_used = 1'b1;
        state_d  = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        memToReg      = M2R_MDR;
        state_d       = S_FETCH;
      end
      S_MEMWR: begin
        mem_write_raw = 1'b1;
        iorD          = 1'b1;
        state_d       = S_FETCH;
      end
      // Unknown funct skips ALUWB so no register write is issued.
      S_EXEC: begin
        aluSrcA  = 1'b1;
        alu_op   = ALUOP_FUNCT;
        alu_used = 1'b1;
        if (funct_ok) begin
          state_d = S_ALUWB;
        end else begin
          illegalOp = 1'b1;
          state_d   = ILLEGAL_NEXT;
        end
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        regDst        = REGDST_RD;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA  = 1'b1;
        alu_op   = ALUOP_SUB;
        alu_used = 1'b1;
        branch   = 1'b1;
        pcSrc    = PCSRC_ALUOUT;
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        aluSrcA  = 1'b1;
        aluSrcB  = SRCB_IMM;
        alu_used = 1'b1;
        state_d  = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pcSrc    = PCSRC_JUMP;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
`ifdef MC_MAIN_CONTROLLER_JAL_EN
      S_JAL: begin
        reg_write_raw = 1'b1;
        regDst        = REGDST_RA;
        memToReg      = M2R_PC;
        pcSrc         = PCSRC_JUMP;
        pc_write      = 1'b1;
        state_d       = S_FETCH;
      end
`endif
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Write strobes are squashed combinationally while reset is held.
  assign pcEn     = ~rst & (pc_write | (branch & zero));
  assign irWrite  = ~rst & ir_write_raw;
  assign memWrite = ~rst & mem_write_raw;
  assign regWrite = ~rst & reg_write_raw;
  assign aluCtrl  = alu_used ? dec_ctrl : ALU_AND;
  assign state    = state_q;

endmodule
